tournament_bp: RTL and testbench

- Parametrised, clocked tournament branch predictor for the pipeline fetch stage.
- Per-PC local predictor: local history table plus local PHT.
- Global predictor: GHR, optionally gshare-hashed, plus global PHT.
- A per-PC chooser selects between the two predictors.
- Adds over the previous predictor:
  - registered state with an asynchronous reset;
  - power-up table-init FSM;
  - speculative GHR with mispredict recovery;
  - a real chooser update from resolved outcomes.

---
 rtl/tournament_bp.sv | 151 +++++++++++++++
 tb/tb_tournament_bp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tournament_bp.sv
// Tournament branch predictor: per-PC local history + gshare global predictor,
// arbitrated by a per-PC chooser, with power-up table init and speculative GHR.
module tournament_bp #(
  parameter int PC_W         = 32,
  parameter int LHT_BITS     = 10,
  parameter int LHIST_W      = 10,
  parameter int GHR_W        = 12,
  parameter int CHOOSER_BITS = 12,
  parameter int GSHARE       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              pre_branch_o,
  output logic              pre_taken_o,
  output logic [PC_W-1:0]   pre_addr_o,
  output logic              pre_sel_o,
  output logic              pre_local_o,
  output logic              pre_global_o,
  output logic [GHR_W-1:0]  pre_ghr_o,
  output logic              ready_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic              upd_local_i,
  input  logic              upd_global_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  input  logic              upd_mispredict_i
);

  localparam int MAX_A = (LHT_BITS > LHIST_W) ? LHT_BITS : LHIST_W;
  localparam int MAX_B = (GHR_W > CHOOSER_BITS) ? GHR_W : CHOOSER_BITS;
  localparam int IDX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   initIdx;
  logic [GHR_W-1:0]   ghr;

  logic [LHIST_W-1:0] lht     [2**LHT_BITS];
  logic [1:0]         lpht    [2**LHIST_W];
  logic [1:0]         gpht    [2**GHR_W];
  logic [1:0]         chooser [2**CHOOSER_BITS];

  function automatic logic [GHR_W-1:0] hashIdx(input logic [GHR_W-1:0] h,
                                               input logic [PC_W-1:0] pc);
    if (GSHARE != 0) return h ^ pc[GHR_W+1:2];
    else             return h;
  endfunction

  function automatic logic [1:0] counterStep(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic               running;
  logic               isBranch;
  logic               localPred;
  logic               globalPred;
  logic               selBit;
  logic               predTaken;
  logic [12:0]        bImm;
  logic [PC_W-1:0]    bOff;
  logic [LHIST_W-1:0] lhistF;

  assign running  = (state == RUN);
  assign isBranch = (inst_i[6:0] == 7'b1100011);
  assign bImm     = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign bOff     = {{(PC_W-13){bImm[12]}}, bImm};

  // Reads see pre-edge contents, so a same-cycle update never affects this prediction.
  always_comb begin
    lhistF     = lht[pc_i[LHT_BITS+1:2]];
    localPred  = lpht[lhistF][1];
    globalPred = gpht[hashIdx(ghr, pc_i)][1];
    selBit     = chooser[pc_i[CHOOSER_BITS+1:2]][1];
    predTaken  = running & isBranch & (selBit ? globalPred : localPred);
  end

  assign pre_branch_o = isBranch;
  assign pre_taken_o  = predTaken;
  assign pre_addr_o   = pc_i + (predTaken ? bOff : PC_W'(4));
  assign pre_sel_o    = running & selBit;
  assign pre_local_o  = running & isBranch & localPred;
  assign pre_global_o = running & isBranch & globalPred;
  assign pre_ghr_o    = ghr;
  assign ready_o      = running;

  logic [LHT_BITS-1:0]     updLhtIdx;
  logic [LHIST_W-1:0]      updHist;
  logic [LHIST_W-1:0]      updHistNext;
  logic [GHR_W-1:0]        updGIdx;
  logic [CHOOSER_BITS-1:0] updChIdx;
  logic [1:0]              chNext;
  logic                    localRight;
  logic                    globalRight;

  always_comb begin
    updLhtIdx   = upd_pc_i[LHT_BITS+1:2];
    updHist     = lht[updLhtIdx];
    updHistNext = LHIST_W'({updHist, upd_taken_i});
    updGIdx     = hashIdx(upd_ghr_i, upd_pc_i);
    updChIdx    = upd_pc_i[CHOOSER_BITS+1:2];
    localRight  = (upd_local_i == upd_taken_i);
    globalRight = (upd_global_i == upd_taken_i);
    chNext      = chooser[updChIdx];
    if (globalRight && !localRight)      chNext = counterStep(chooser[updChIdx], 1'b1);
    else if (localRight && !globalRight) chNext = counterStep(chooser[updChIdx], 1'b0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      initIdx <= '0;
    end else if (state == INIT) begin
      if (&initIdx) state   <= RUN;
      else          initIdx <= initIdx + 1'b1;
    end
  end

  // Recovery wins over a same-cycle fetch shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (running) begin
      if (upd_valid_i && upd_mispredict_i) ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
      else if (fetch_en_i && isBranch)     ghr <= GHR_W'({ghr, predTaken});
    end
  end

  always_ff @(posedge clk) begin
    if (!running) begin
      lht[initIdx[LHT_BITS-1:0]]         <= '0;
      lpht[initIdx[LHIST_W-1:0]]         <= 2'b01;
      gpht[initIdx[GHR_W-1:0]]           <= 2'b01;
      chooser[initIdx[CHOOSER_BITS-1:0]] <= 2'b01;
    end else if (upd_valid_i) begin
      lht[updLhtIdx]     <= updHistNext;
      lpht[updHist]      <= counterStep(lpht[updHist], upd_taken_i);
      gpht[updGIdx]      <= counterStep(gpht[updGIdx], upd_taken_i);
      chooser[updChIdx]  <= chNext;
    end
  end

  logic unusedBits;
  assign unusedBits = ^{upd_pc_i, inst_i[24:12]};

endmodule

// File: tb/tb_tournament_bp.sv
// Bench for tournament_bp: default instance driven from a vector table through a
// scoreboard queue, plus a small-parameter instance for init length and saturation.
module tb_tournament_bp;

  localparam logic [31:0] BNEG8 = 32'hFE000CE3;  // B-type, imm = -8
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        fetchEn, preBranch, preTaken, preSel, preLocal, preGlobal, ready;
  logic [31:0] pc, inst, preAddr, updPc;
  logic [11:0] preGhr, updGhr;
  logic        updValid, updTaken, updLocal, updGlobal, updMisp;

  logic        sFetchEn, sPreBranch, sPreTaken, sPreSel, sPreLocal, sPreGlobal, sReady;
  logic [31:0] sPc, sInst, sPreAddr, sUpdPc;
  logic [1:0]  sPreGhr, sUpdGhr;
  logic        sUpdValid, sUpdTaken, sUpdLocal, sUpdGlobal, sUpdMisp;

  tournament_bp dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetchEn), .pc_i(pc), .inst_i(inst),
    .pre_branch_o(preBranch), .pre_taken_o(preTaken), .pre_addr_o(preAddr),
    .pre_sel_o(preSel), .pre_local_o(preLocal), .pre_global_o(preGlobal),
    .pre_ghr_o(preGhr), .ready_o(ready), .upd_valid_i(updValid), .upd_pc_i(updPc),
    .upd_taken_i(updTaken), .upd_local_i(updLocal), .upd_global_i(updGlobal),
    .upd_ghr_i(updGhr), .upd_mispredict_i(updMisp)
  );

  tournament_bp #(.PC_W(32), .LHT_BITS(2), .LHIST_W(1), .GHR_W(2),
                  .CHOOSER_BITS(2), .GSHARE(1)) dutSmall (
    .clk(clk), .rst(rst), .fetch_en_i(sFetchEn), .pc_i(sPc), .inst_i(sInst),
    .pre_branch_o(sPreBranch), .pre_taken_o(sPreTaken), .pre_addr_o(sPreAddr),
    .pre_sel_o(sPreSel), .pre_local_o(sPreLocal), .pre_global_o(sPreGlobal),
    .pre_ghr_o(sPreGhr), .ready_o(sReady), .upd_valid_i(sUpdValid), .upd_pc_i(sUpdPc),
    .upd_taken_i(sUpdTaken), .upd_local_i(sUpdLocal), .upd_global_i(sUpdGlobal),
    .upd_ghr_i(sUpdGhr), .upd_mispredict_i(sUpdMisp)
  );

  typedef struct {
    logic        fetchEn;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken, updLocal, updGlobal;
    logic [11:0] updGhr;
    logic        updMisp;
    logic        expBranch, expTaken;
    logic [31:0] expAddr;
    logic        expSel, expLocal, expGlobal;
    logic [11:0] expGhr;
  } vec_t;

  vec_t vecs[16];
  vec_t sbq[$];
  int assertCount = 0;
  int failCount   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fe, input logic [31:0] p, input logic [31:0] in,
                              input logic uv, input logic [31:0] up, input logic ut,
                              input logic ul, input logic ug, input logic [11:0] ugh,
                              input logic um, input logic eb, input logic et,
                              input logic [31:0] ea, input logic es, input logic el,
                              input logic eg, input logic [11:0] egh);
    vec_t v;
    v.fetchEn = fe; v.pc = p; v.inst = in; v.updValid = uv; v.updPc = up;
    v.updTaken = ut; v.updLocal = ul; v.updGlobal = ug; v.updGhr = ugh; v.updMisp = um;
    v.expBranch = eb; v.expTaken = et; v.expAddr = ea; v.expSel = es;
    v.expLocal = el; v.expGlobal = eg; v.expGhr = egh;
    return v;
  endfunction

  task automatic applyVec(input int n, input vec_t v);
    vec_t e;
    @(negedge clk);
    fetchEn = v.fetchEn; pc = v.pc; inst = v.inst; updValid = v.updValid;
    updPc = v.updPc; updTaken = v.updTaken; updLocal = v.updLocal;
    updGlobal = v.updGlobal; updGhr = v.updGhr; updMisp = v.updMisp;
    sbq.push_back(v);
    #1;
    e = sbq.pop_front();
    $display("vec %0d: pc=0x%0h branch=%0b taken=%0b addr=0x%0h sel=%0b ghr=0x%0h",
             n, pc, preBranch, preTaken, preAddr, preSel, preGhr);
    check($sformatf("v%0d_branch", n), 64'(preBranch), 64'(e.expBranch));
    check($sformatf("v%0d_taken", n),  64'(preTaken),  64'(e.expTaken));
    check($sformatf("v%0d_addr", n),   64'(preAddr),   64'(e.expAddr));
    check($sformatf("v%0d_sel", n),    64'(preSel),    64'(e.expSel));
    check($sformatf("v%0d_local", n),  64'(preLocal),  64'(e.expLocal));
    check($sformatf("v%0d_global", n), 64'(preGlobal), 64'(e.expGlobal));
    check($sformatf("v%0d_ghr", n),    64'(preGhr),    64'(e.expGhr));
  endtask

  task automatic initWait(output int mainN, output int smallN);
    mainN = -1;
    smallN = -1;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk);
      #1;
      if (smallN < 0 && sReady) smallN = n;
      if (ready) begin
        mainN = n;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int mainN, smallN;
    rst = 1'b1;
    fetchEn = 0; pc = 0; inst = NOP; updValid = 0; updPc = 0; updTaken = 0;
    updLocal = 0; updGlobal = 0; updGhr = 0; updMisp = 0;
    sFetchEn = 0; sPc = 0; sInst = NOP; sUpdValid = 0; sUpdPc = 0; sUpdTaken = 0;
    sUpdLocal = 0; sUpdGlobal = 0; sUpdGhr = 0; sUpdMisp = 0;

    //            fe  pc      inst   uv upc     ut ul ug ughr    um  eb et addr     es el eg eghr
    vecs[0]  = mk(1'b0, 32'h100, BNEG8, 0, 32'h0,   0, 0, 0, 12'h0,   0, 1, 0, 32'h104, 0, 0, 0, 12'h0);
    vecs[1]  = mk(1'b1, 32'h200, NOP,   0, 32'h0,   0, 0, 0, 12'h0,   0, 0, 0, 32'h204, 0, 0, 0, 12'h0);
    vecs[2]  = mk(1'b0, 32'h300, NOP,   1, 32'h200, 1, 0, 1, 12'h0,   0, 0, 0, 32'h304, 0, 0, 0, 12'h0);
    vecs[3]  = mk(1'b0, 32'h300, NOP,   1, 32'h200, 1, 0, 1, 12'h0,   0, 0, 0, 32'h304, 0, 0, 0, 12'h0);
    vecs[4]  = mk(1'b0, 32'h200, NOP,   1, 32'h200, 1, 1, 0, 12'h0,   0, 0, 0, 32'h204, 1, 0, 0, 12'h0);
    vecs[5]  = mk(1'b0, 32'h200, NOP,   1, 32'h200, 1, 1, 0, 12'h0,   0, 0, 0, 32'h204, 1, 0, 0, 12'h0);
    vecs[6]  = mk(1'b0, 32'h200, NOP,   0, 32'h0,   0, 0, 0, 12'h0,   0, 0, 0, 32'h204, 0, 0, 0, 12'h0);
    vecs[7]  = mk(1'b0, 32'h300, NOP,   1, 32'h100, 1, 0, 1, 12'h0,   0, 0, 0, 32'h304, 0, 0, 0, 12'h0);
    vecs[8]  = mk(1'b0, 32'h300, NOP,   1, 32'h100, 1, 0, 1, 12'h0,   0, 0, 0, 32'h304, 0, 0, 0, 12'h0);
    vecs[9]  = mk(1'b1, 32'h100, BNEG8, 0, 32'h0,   0, 0, 0, 12'h0,   0, 1, 1, 32'h0F8, 1, 1, 1, 12'h0);
    vecs[10] = mk(1'b1, 32'h400, BNEG8, 0, 32'h0,   0, 0, 0, 12'h0,   0, 1, 1, 32'h3F8, 0, 1, 0, 12'h1);
    vecs[11] = mk(1'b1, 32'h200, BNEG8, 0, 32'h0,   0, 0, 0, 12'h0,   0, 1, 0, 32'h204, 0, 0, 0, 12'h3);
    vecs[12] = mk(1'b1, 32'h300, NOP,   1, 32'h500, 1, 0, 0, 12'h002, 1, 0, 0, 32'h304, 0, 0, 0, 12'h6);
    vecs[13] = mk(1'b1, 32'h400, BNEG8, 1, 32'h600, 1, 0, 0, 12'h005, 1, 1, 1, 32'h3F8, 0, 1, 0, 12'h5);
    vecs[14] = mk(1'b0, 32'h300, NOP,   0, 32'h0,   0, 0, 0, 12'h3FF, 1, 0, 0, 32'h304, 0, 0, 0, 12'h00B);
    vecs[15] = mk(1'b0, 32'h300, NOP,   0, 32'h0,   0, 0, 0, 12'h0,   0, 0, 0, 32'h304, 0, 0, 0, 12'h00B);

    // Power-up init
    repeat (3) @(negedge clk);
    check("ready_in_reset", 64'(ready), 64'd0);
    rst = 1'b0;
    initWait(mainN, smallN);
    $display("init: main ready after %0d edges, small after %0d", mainN, smallN);
    check("init_len_main", 64'(mainN), 64'd4096);
    check("init_len_small", 64'(smallN), 64'd4);

    for (int i = 0; i < 16; i++) applyVec(i, vecs[i]);

    // Mid-RUN reset with fetch and mispredict traffic that must be ignored during INIT
    @(negedge clk);
    rst = 1'b1; fetchEn = 1; pc = 32'h100; inst = BNEG8;
    updValid = 1; updMisp = 1; updTaken = 1; updGhr = 12'hFFF; updPc = 32'h100;
    #1;
    check("rst_ready_main", 64'(ready), 64'd0);
    check("rst_ready_small", 64'(sReady), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_taken", 64'(preTaken), 64'd0);
    check("init_addr", 64'(preAddr), 64'h104);
    check("init_sel", 64'(preSel), 64'd0);
    check("init_branch", 64'(preBranch), 64'd1);
    initWait(mainN, smallN);
    $display("reinit: main ready after %0d edges, small after %0d", mainN, smallN);
    check("reinit_len_main", 64'(mainN), 64'd4096);
    check("reinit_len_small", 64'(smallN), 64'd4);
    check("reinit_ghr", 64'(preGhr), 64'd0);
    fetchEn = 0; updValid = 0; updMisp = 0;
    #1;
    $display("post-reset: pc=0x100 taken=%0b addr=0x%0h", preTaken, preAddr);
    check("post_rst_taken", 64'(preTaken), 64'd0);
    check("post_rst_addr", 64'(preAddr), 64'h104);

    // Small instance: local saturation with a 1-bit local history
    @(negedge clk);
    sPc = 32'h4; sInst = BNEG8; sUpdPc = 32'h4; sUpdTaken = 1;
    sUpdLocal = 1; sUpdGlobal = 1; sUpdGhr = 2'b00; sUpdValid = 1;
    repeat (4) @(negedge clk);
    sUpdValid = 0;
    #1;
    $display("small after 4 taken: local=%0b global=%0b taken=%0b", sPreLocal, sPreGlobal, sPreTaken);
    check("sat4_local", 64'(sPreLocal), 64'd1);
    check("sat4_global", 64'(sPreGlobal), 64'd1);
    check("sat4_taken", 64'(sPreTaken), 64'd1);
    check("sat4_addr", 64'(sPreAddr), 64'hFFFF_FFFC);
    @(negedge clk);
    sUpdValid = 1;
    repeat (2) @(negedge clk);
    sUpdValid = 0;
    #1;
    $display("small after 6 taken: local=%0b", sPreLocal);
    check("sat6_local", 64'(sPreLocal), 64'd1);
    @(negedge clk);
    sUpdTaken = 0; sUpdLocal = 0; sUpdGlobal = 0; sUpdValid = 1;
    repeat (2) @(negedge clk);
    sUpdValid = 0;
    #1;
    $display("small after 2 not-taken: local=%0b sel=%0b", sPreLocal, sPreSel);
    check("nt2_local", 64'(sPreLocal), 64'd0);
    check("nt2_sel", 64'(sPreSel), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
